// File: rtl/switch_debounce_encoder.sv
// switch_debounce_encoder: synchronises and debounces four push-switches, turns
// debounced releases into one-cycle button events (DV + 2-bit ID), and flags the
// Switch 1 + Switch 2 reset combination while suppressing the events it would cause.
// Build option: define EVENT_ON_PRESS_EN to raise events on debounced presses
// instead of releases; ports and latency are identical in both builds.
// Latency: raw step to debounced level is DEBOUNCE_LIMIT+2 edges; event DV one edge later.
// Backpressure: none; DV is a one-cycle pulse the consumer must sample every cycle.

module switch_debounce_encoder #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_Switch_1,
  output logic       o_Switch_2,
  output logic       o_Switch_3,
  output logic       o_Switch_4,
  output logic       o_Reset_Combo,
  output logic       o_Button_DV,
  output logic [1:0] o_Button_ID
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [3:0]            raw;
  logic [3:0]            meta_q;
  logic [3:0]            sync_q;
  logic [3:0]            sw_q, sw_d;
  logic [3:0]            sw_prev_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            pending_q, pending_d;
  logic                  combo_prev_q;
  logic                  latch_q, latch_d;

  logic                  combo;
  logic                  combo_rise;
  logic [3:0]            edge_det;
  logic [3:0]            edge_ok;
  logic [3:0]            served;
  logic [1:0]            id_sel;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Per channel: count edges the synchronised input disagrees with the debounced
  // level; the level flips on the edge the count is already at its limit.
  always_comb begin
    sw_d  = sw_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          sw_d[i]  = sync_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounced level changes seen one edge late, which is when they become pending.
`ifdef EVENT_ON_PRESS_EN
  assign edge_det = sw_q & ~sw_prev_q;
`else
  assign edge_det = ~sw_q & sw_prev_q;
`endif

  assign combo      = sw_q[0] & sw_q[1];
  assign combo_rise = combo & ~combo_prev_q;

  // Channels 0/1 are muted while the combo is latched and on the edge it forms.
  assign edge_ok = edge_det & {2'b11, {2{~(latch_q | combo_rise)}}};

  // Lowest pending index is the one presented and retired this cycle.
  always_comb begin
    served = '0;
    id_sel = 2'd0;
    if (pending_q[0]) begin
      served[0] = 1'b1;
      id_sel    = 2'd0;
    end else if (pending_q[1]) begin
      served[1] = 1'b1;
      id_sel    = 2'd1;
    end else if (pending_q[2]) begin
      served[2] = 1'b1;
      id_sel    = 2'd2;
    end else if (pending_q[3]) begin
      served[3] = 1'b1;
      id_sel    = 2'd3;
    end
  end

  // Pending set: retire the served bit, merge new edges, and drop the 0/1 events
  // that a forming combo would otherwise leave behind.
  always_comb begin
    pending_d = (pending_q & ~served) | edge_ok;
    if (combo_rise) begin
      pending_d[1:0] = 2'b00;
    end
    latch_d = latch_q;
    if (combo_rise) begin
      latch_d = 1'b1;
    end else if (!sw_q[0] && !sw_q[1]) begin
      latch_d = 1'b0;
    end
  end

  // All state: two-flop synchronisers, debounce counters, edge history, pending, latch.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      meta_q       <= '0;
      sync_q       <= '0;
      sw_q         <= '0;
      sw_prev_q    <= '0;
      cnt_q        <= '0;
      pending_q    <= '0;
      combo_prev_q <= 1'b0;
      latch_q      <= 1'b0;
    end else begin
      meta_q       <= raw;
      sync_q       <= meta_q;
      sw_q         <= sw_d;
      sw_prev_q    <= sw_q;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      combo_prev_q <= combo;
      latch_q      <= latch_d;
    end
  end

  assign o_Switch_1    = sw_q[0];
  assign o_Switch_2    = sw_q[1];
  assign o_Switch_3    = sw_q[2];
  assign o_Switch_4    = sw_q[3];
  assign o_Reset_Combo = combo;
  assign o_Button_DV   = |pending_q;
  assign o_Button_ID   = id_sel;

endmodule

// File: tb/tb_switch_debounce_encoder.sv
// tb_switch_debounce_encoder: directed stimulus for the switch front-end with an
// event-level reference model compared every cycle, plus hand-computed literal
// expectations for the scenario timings and event orderings.

module tb_switch_debounce_encoder;

  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic       sw1, sw2, sw3, sw4, combo, dv;
  logic [1:0] id;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mark        = 0;
  int first_id    = 0;
  int hi_ids      = 0;

  logic [1:0] log_id[$];

  switch_debounce_encoder #(.DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch_1    (raw[0]),
    .i_Switch_2    (raw[1]),
    .i_Switch_3    (raw[2]),
    .i_Switch_4    (raw[3]),
    .o_Switch_1    (sw1),
    .o_Switch_2    (sw2),
    .o_Switch_3    (sw3),
    .o_Switch_4    (sw4),
    .o_Reset_Combo (combo),
    .o_Button_DV   (dv),
    .o_Button_ID   (id)
  );

  always #5 clk = ~clk;

  // Reference model: raw level two edges old, a level flips after LIM consecutive
  // disagreeing samples, events queue as a set served lowest-first.
  bit [3:0] m_h1, m_h2, m_lvl, m_lvl_prev, m_pend;
  int       m_run[4];
  bit       m_latch, m_combo_prev;

  function automatic logic [1:0] lowest(bit [3:0] p);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (p[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_step();
    bit [3:0] ev;
    bit [3:0] served;
    bit       combo_now;
    bit       rise;
    if (!rst_n) begin
      m_h1 = 0; m_h2 = 0; m_lvl = 0; m_lvl_prev = 0; m_pend = 0;
      m_latch = 0; m_combo_prev = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      served = 0;
      if (m_pend != 0) served[lowest(m_pend)] = 1'b1;
`ifdef EVENT_ON_PRESS_EN
      ev = m_lvl & ~m_lvl_prev;
`else
      ev = m_lvl_prev & ~m_lvl;
`endif
      combo_now = m_lvl[0] & m_lvl[1];
      rise = combo_now & ~m_combo_prev;
      if (m_latch || rise) ev[1:0] = 2'b00;
      m_pend = (m_pend & ~served) | ev;
      if (rise) m_pend[1:0] = 2'b00;
      if (rise) m_latch = 1'b1;
      else if (!m_lvl[0] && !m_lvl[1]) m_latch = 1'b0;
      m_combo_prev = combo_now;
      m_lvl_prev = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_h2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == LIM) begin
            m_lvl[i] = m_h2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = raw;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
  end

  // Every-cycle comparison of all outputs against the model, plus an event log.
  always @(negedge clk) begin
    logic [7:0] got;
    logic [7:0] want;
    got  = {sw4, sw3, sw2, sw1, combo, dv, id};
    want = {m_lvl, m_lvl[0] & m_lvl[1], |m_pend, lowest(m_pend)};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL percycle cyc=%0d got=%b want=%b (sw4..1,combo,dv,id)", cyc, got, want);
    end
    if (dv === 1'b1) log_id.push_back(id);
  end

  task automatic check(string name, int got, int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    check("reset_state", int'({sw4, sw3, sw2, sw1, combo, dv, id}), 0);

    // 1: 3-cycle glitch on switch 3 is filtered
    raw[2] = 1'b1; tick(3); raw[2] = 1'b0; tick(10);
    check("t1_sw3_low", sw3, 0);
    check("t1_no_dv", log_id.size(), 0);

    // 2: switch 2 held 20 cycles; 6-edge latency both ways; one event ID 1
    mark = log_id.size();
    raw[1] = 1'b1; tick(5);
    check("t2_rise_edge5", sw2, 0);
    tick(1);
    check("t2_rise_edge6", sw2, 1);
    tick(14); raw[1] = 1'b0; tick(5);
    check("t2_fall_edge5", sw2, 1);
    tick(1);
    check("t2_fall_edge6", sw2, 0);
    tick(1);
`ifndef EVENT_ON_PRESS_EN
    check("t2_dv", dv, 1);
    check("t2_id", id, 1);
`endif
    tick(1);
    check("t2_dv_once", dv, 0);
    tick(4);
    check("t2_event_count", log_id.size() - mark, 1);
    first_id = (log_id.size() > mark) ? int'(log_id[mark]) : -1;
    check("t2_event_id", first_id, 1);

    // 3: switches 1,3,4 released together -> IDs 0,2,3 on consecutive cycles
    raw = 4'b1101; tick(10);
    mark = log_id.size();
    raw = 4'b0000; tick(6);
    check("t3_levels_low", int'({sw4, sw3, sw2, sw1}), 0);
`ifndef EVENT_ON_PRESS_EN
    tick(1);
    check("t3_ev0", int'({dv, id}), 4);
    tick(1);
    check("t3_ev1", int'({dv, id}), 6);
    tick(1);
    check("t3_ev2", int'({dv, id}), 7);
    tick(1);
    check("t3_idle", dv, 0);
    check("t3_event_count", log_id.size() - mark, 3);
`endif
    tick(4);

    // 4: reset combo; no events for switches 1/2; lone switch 1 afterwards works
    raw = 4'b0011; tick(6);
    check("t4_combo_high", combo, 1);
    tick(4);
    mark = log_id.size();
    raw = 4'b0000; tick(10);
    check("t4_combo_low", combo, 0);
    check("t4_no_dv", log_id.size() - mark, 0);
    mark = log_id.size();
    raw = 4'b0001; tick(10); raw = 4'b0000; tick(10);
    check("t4_lone_count", log_id.size() - mark, 1);
    first_id = (log_id.size() > mark) ? int'(log_id[mark]) : -1;
    check("t4_lone_id", first_id, 0);

    // 5: reset with two events pending and switch 1 mid-count
    raw = 4'b1100; tick(10);
    raw = 4'b0000; tick(4);
    raw[0] = 1'b1; tick(3);
`ifndef EVENT_ON_PRESS_EN
    check("t5_pending_before", int'({dv, id}), 6);
`endif
    rst_n = 1'b0; tick(1);
    check("t5_reset_out", int'({sw4, sw3, sw2, sw1, combo, dv, id}), 0);
    rst_n = 1'b1;
    mark = log_id.size();
    tick(5);
    check("t5_restart_edge5", sw1, 0);
    tick(1);
    check("t5_restart_edge6", sw1, 1);
    raw[0] = 1'b0; tick(10);
    hi_ids = 0;
    for (int i = mark; i < log_id.size(); i++) if (log_id[i] >= 2'd2) hi_ids++;
    check("t5_no_stale", hi_ids, 0);

    // 6: switch 4 press and hold; event on press or on release depending on build
    mark = log_id.size();
    raw[3] = 1'b1; tick(6);
    check("t6_sw4_high", sw4, 1);
    tick(1);
`ifdef EVENT_ON_PRESS_EN
    check("t6_press_dv", int'({dv, id}), 7);
`else
    check("t6_press_quiet", dv, 0);
`endif
    tick(5);
    raw[3] = 1'b0; tick(6);
    check("t6_sw4_low", sw4, 0);
    tick(1);
`ifdef EVENT_ON_PRESS_EN
    check("t6_release_quiet", dv, 0);
`else
    check("t6_release_dv", int'({dv, id}), 7);
`endif
    tick(3);
    check("t6_event_count", log_id.size() - mark, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
